// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the memory-mapped UART transmitter
package uart_pkg;

    localparam int unsigned CTRL_OFS = 2;

    localparam int RDY_BIT  = 0;
    localparam int IDLE_BIT = 1;
    localparam int OVR_BIT  = 2;
    localparam int IE_BIT   = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - circular first-word-fall-through FIFO feeding the transmitter
module tx_fifo #(
    parameter int WBITS = 8,
    parameter int FIFOB = 3
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             PUSH,
    input  logic [WBITS-1:0] DIN,
    input  logic             POP,
    output logic [WBITS-1:0] DOUT,
    output logic             FULL,
    output logic             EMPTY,
    output logic [FIFOB:0]   COUNT
);

    localparam int DEPTH = 1 << FIFOB;

    logic [WBITS-1:0] mem [DEPTH];
    logic [FIFOB-1:0] wr_ptr;
    logic [FIFOB-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign FULL    = (COUNT == (FIFOB+1)'(DEPTH));
    assign EMPTY   = (COUNT == '0);
    // A push into a full FIFO is refused even when a pop frees a slot this cycle.
    assign push_ok = PUSH && !FULL;
    assign pop_ok  = POP && !EMPTY;
    assign DOUT    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - bus-mapped 8N1 serial transmitter with FIFO and interrupt
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int               ABITS   = 16,
    parameter int               DBITS   = 16,
    parameter logic [ABITS-1:0] DADDR   = 16'hFFD0,
    parameter logic [ABITS-1:0] CADDR   = DADDR + ABITS'(CTRL_OFS),
    parameter int               BAUDDIV = 434,
    parameter int               BAUDB   = 9,
    parameter int               FIFOB   = 3
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic [ABITS-1:0] ABUS,
    inout  wire  [DBITS-1:0] RBUS,
    input  logic             RE,
    input  logic [DBITS-1:0] WBUS,
    input  logic             WE,
    output logic             INTR,
    output logic             TXD
);

    logic             data_sel;
    logic             ctrl_sel;
    logic             data_wr;
    logic             ctrl_wr;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [FIFOB:0]   fifo_count;
    logic [1:0]       state;
    logic [BAUDB-1:0] baud_cnt;
    logic             baud_end;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             ovr;
    logic             ie;
    logic [DBITS-1:0] ctrl_word;
    logic [DBITS-1:0] rdata;
    logic             unused_wbus;

    assign data_sel    = (ABUS == DADDR);
    assign ctrl_sel    = (ABUS == CADDR);
    assign data_wr     = WE && data_sel;
    assign ctrl_wr     = WE && ctrl_sel;
    assign baud_end    = (baud_cnt == BAUDB'(BAUDDIV - 1));
    assign unused_wbus = ^WBUS[DBITS-1:IE_BIT+1];

    // Pop from IDLE, or at the end of the stop bit so frames run back to back.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) ||
                       ((state == ST_STOP) && baud_end && (bit_idx == 3'(STOP_BITS - 1))));

    tx_fifo #(
        .WBITS (8),
        .FIFOB (FIFOB)
    ) u_fifo (
        .CLK   (CLK),
        .INIT  (INIT),
        .PUSH  (data_wr),
        .DIN   (WBUS[7:0]),
        .POP   (fifo_pop),
        .DOUT  (fifo_dout),
        .FULL  (fifo_full),
        .EMPTY (fifo_empty),
        .COUNT (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TXD      <= 1'b1;
        end else begin
            case (state)
                ST_START: begin
                    TXD <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    TXD <= shift[0];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    TXD <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            if (fifo_pop) begin
                                shift <= fifo_dout;
                                state <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    TXD <= 1'b1;
                    if (fifo_pop) begin
                        shift    <= fifo_dout;
                        baud_cnt <= '0;
                        state    <= ST_START;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            ovr  <= 1'b0;
            ie   <= 1'b0;
            INTR <= 1'b0;
        end else begin
            if (data_wr && fifo_full) begin
                ovr <= 1'b1;
            end else if (ctrl_wr && !WBUS[OVR_BIT]) begin
                ovr <= 1'b0;
            end
            if (ctrl_wr) begin
                ie <= WBUS[IE_BIT];
            end
            INTR <= ie && !fifo_full;
        end
    end

    always_comb begin
        ctrl_word           = '0;
        ctrl_word[RDY_BIT]  = !fifo_full;
        ctrl_word[IDLE_BIT] = fifo_empty && (state == ST_IDLE);
        ctrl_word[OVR_BIT]  = ovr;
        ctrl_word[IE_BIT]   = ie;
    end

    always_comb begin
        rdata = ctrl_word;
        if (data_sel) begin
            rdata            = '0;
            rdata[FIFOB:0]   = fifo_count;
        end
    end

    assign RBUS = (RE && (data_sel || ctrl_sel)) ? rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - randomized self-checking bench for uart_tx_dev
module tb_uart_tx_dev;

    localparam int          B     = 4;
    localparam int          FLEN  = 10 * B;
    localparam logic [15:0] DADDR = 16'hFFD0;
    localparam logic [15:0] CADDR = 16'hFFD2;
    localparam logic [15:0] TBPAT = 16'h5A30;

    logic        clk;
    logic        init;
    logic [15:0] abus;
    logic        re;
    logic [15:0] wbus;
    logic        we;
    logic        intr;
    logic        txd;
    logic        tb_drv;
    wire  [15:0] rbus;

    int checks;
    int errors;
    int cyc;

    int         f_start [$];
    logic [7:0] f_data  [$];
    int         last_end;
    logic       m_ovr;
    logic       m_ie;

    assign rbus = tb_drv ? TBPAT : 16'hzzzz;

    uart_tx_dev #(
        .ABITS   (16),
        .DBITS   (16),
        .DADDR   (DADDR),
        .CADDR   (CADDR),
        .BAUDDIV (B),
        .BAUDB   (4),
        .FIFOB   (3)
    ) dut (
        .CLK  (clk),
        .INIT (init),
        .ABUS (abus),
        .RBUS (rbus),
        .RE   (re),
        .WBUS (wbus),
        .WE   (we),
        .INTR (intr),
        .TXD  (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bytes still queued after posedge t: their pop happens at posedge start-1.
    function automatic int occ_after(input int t);
        int c;
        c = 0;
        foreach (f_start[i]) if (f_start[i] - 1 > t) c++;
        return c;
    endfunction

    function automatic bit idle_after(input int t);
        foreach (f_start[i]) if (f_start[i] + FLEN - 1 > t) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_txd(input int t);
        int k;
        foreach (f_start[i]) begin
            if (t >= f_start[i] && t < f_start[i] + FLEN) begin
                k = (t - f_start[i]) / B;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return f_data[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_ctrl();
        logic [15:0] v;
        v    = '0;
        v[0] = (occ_after(cyc) < 8);
        v[1] = idle_after(cyc);
        v[2] = m_ovr;
        v[8] = m_ie;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic exp_intr;
        int   n;
        int   s;
        exp_intr = !init && m_ie && (occ_after(cyc) < 8);
        @(posedge clk);
        cyc++;
        n = cyc;
        if (init) begin
            f_start.delete();
            f_data.delete();
            last_end = 0;
            m_ovr    = 1'b0;
            m_ie     = 1'b0;
        end else begin
            if (we && abus == DADDR) begin
                if (occ_after(n - 1) < 8) begin
                    s = (n + 2 > last_end) ? n + 2 : last_end;
                    f_start.push_back(s);
                    f_data.push_back(wbus[7:0]);
                    last_end = s + FLEN;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (we && abus == CADDR) begin
                m_ie = wbus[8];
                if (!wbus[2]) m_ovr = 1'b0;
            end
        end
        #1;
        chk("txd", {15'b0, txd}, {15'b0, exp_txd(n)});
        chk("intr", {15'b0, intr}, {15'b0, exp_intr});
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        abus = a;
        wbus = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input string tag);
        abus = a;
        re   = 1'b1;
        if (a != DADDR && a != CADDR) tb_drv = 1'b1;
        #1;
        if (a == DADDR)      chk(tag, rbus, 16'(occ_after(cyc)));
        else if (a == CADDR) chk(tag, rbus, exp_ctrl());
        else                 chk(tag, rbus, TBPAT);
        re     = 1'b0;
        tb_drv = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        int          r;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        last_end = 0;
        m_ovr    = 1'b0;
        m_ie     = 1'b0;
        init     = 1'b1;
        abus     = '0;
        re       = 1'b0;
        wbus     = '0;
        we       = 1'b0;
        tb_drv   = 1'b0;

        ticks(2);
        init = 1'b0;
        tick();
        rd(CADDR, "reset_ctrl");
        rd(DADDR, "reset_data");

        wr(DADDR, 16'h1255);
        ticks(FLEN + 2);
        rd(CADDR, "single_done_ctrl");

        wr(DADDR, {8'($urandom), 8'hA5});
        wr(DADDR, {8'($urandom), 8'h3C});
        tick();
        rd(DADDR, "b2b_count");
        ticks(2 * FLEN + 2);
        rd(CADDR, "b2b_done_ctrl");

        wr(DADDR, 16'($urandom));
        ticks(2);
        init = 1'b1;
        tick();
        init = 1'b0;
        rd(CADDR, "midreset_ctrl");
        rd(DADDR, "midreset_data");
        tick();

        wr(DADDR, 16'($urandom));
        ticks(2);
        for (int i = 0; i < 8; i++) wr(DADDR, 16'($urandom));
        rd(CADDR, "ovf_full_ctrl");
        rd(DADDR, "ovf_full_count");
        wr(DADDR, 16'($urandom));
        rd(CADDR, "ovf_set_ctrl");
        wr(CADDR, 16'h0000);
        rd(CADDR, "ovf_clr_ctrl");
        ticks(10 * FLEN);

        wr(CADDR, 16'h0100);
        ticks(2);
        rd(CADDR, "ie_ctrl");
        for (int i = 0; i < 9; i++) wr(DADDR, 16'($urandom));
        rd(CADDR, "ie_full_ctrl");
        ticks(FLEN + 4);

        rd(16'hFFF0, "iso_read");
        wr(16'hFFF0, 16'hFFFF);
        wr(16'hFFD4, 16'h0000);
        rd(CADDR, "iso_ctrl");
        rd(DADDR, "iso_data");
        ticks(10 * FLEN);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 59);
            d = 16'($urandom);
            if (r == 0) begin
                init = 1'b1;
                tick();
                init = 1'b0;
            end else if (r < 24) wr(DADDR, d);
            else if (r < 28)     wr(CADDR, d);
            else if (r < 34)     rd(DADDR, "rand_data");
            else if (r < 40)     rd(CADDR, "rand_ctrl");
            else if (r < 43)     rd(16'hFF00 | {8'b0, d[7:0]}, "rand_iso");
            else if (r < 46)     wr(16'hFFE0, d);
            else                 tick();
        end
        ticks(10 * FLEN);
        rd(CADDR, "final_ctrl");
        rd(DADDR, "final_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
